sca_reg_unit: RTL and testbench
===============================

SCA_REG_UNIT -- requirements
Module: sca_reg_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: valid_in  input  1  decoded instruction present this cycle.
REQ-004 SHALL have port: stall  input  1  pipeline hold; overrides valid_in.
REQ-005 SHALL have port: sca_reg_op  input  2  decoder op.
  - 00 = INCRI
  - 01 = INCRJ
  - 10 = SETN
  - 11 = no scalar update
REQ-006 SHALL have port: imm  input  32  immediate from decoder, used by SETN only.
REQ-007 SHALL have port: reg_i  output  32  loop index i.
REQ-008 SHALL have port: reg_j  output  32  loop index j.
REQ-009 SHALL have port: reg_n  output  32  loop bound n.
REQ-010 SHALL have port: i_wrap  output  1  one-cycle pulse on i wrap.
REQ-011 SHALL have port: j_wrap  output  1  one-cycle pulse on j wrap.
REQ-012 SHALL have port: done  output  1  sticky; j has completed a full pass.
REQ-013 SHALL have port: op_count  output  32  count of accepted ops.

Function
REQ-014 An op SHALL be accepted on a rising clk edge iff valid_in=1 and stall=0; otherwise all registers hold.
REQ-015 All outputs SHALL be registered and SHALL update the cycle after acceptance (latency 1).
REQ-016 i_wrap and j_wrap SHALL be low in every cycle not immediately following a wrapping acceptance.
REQ-017 INCRI with n!=0: if i+1==n then i<=0 and i_wrap<=1, else i<=i+1.
REQ-018 INCRJ with n!=0: if j+1==n then j<=0, j_wrap<=1 and done<=1, else j<=j+1.
REQ-019 If n==0, INCRI/INCRJ SHALL increment modulo 2^32 with no wrap pulse and no change to done.
REQ-020 If i>=n (only reachable when SETN shrinks n without clearing i), INCRI SHALL set i<=0 and pulse i_wrap; INCRJ SHALL behave the same for j, also setting done.
REQ-021 SETN SHALL load n<=imm, clear i, j and done, and generate no wrap pulse.
REQ-022 Op 11 SHALL leave i, j, n and done unchanged; it still counts as accepted.
REQ-023 done SHALL clear only on SETN or reset.
REQ-024 Arithmetic SHALL be 32-bit unsigned, and the comparison SHALL use the pre-increment value plus one, computed in 33 bits so that i=0xFFFFFFFF never false-matches.
REQ-025 Simultaneous stall=1 and valid_in=1 SHALL drop nothing: the upstream stage holds the op until stall falls.

Reset
REQ-026 rst_n=0 SHALL asynchronously force reg_i=0, reg_j=0, reg_n=0, i_wrap=0, j_wrap=0, done=0, op_count=0.
REQ-027 rst_n assertion mid-operation SHALL discard any op presented in that cycle.
REQ-028 The first op SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SCA_REG_PERF_EN SHALL control op_count.
  - Defined: op_count increments by 1 (mod 2^32) on every accepted op, any encoding.
  - Undefined: op_count is constant 0, no counter flops are synthesized, and all other behaviour is identical.

Verification
REQ-030 Reset, then SETN imm=3, then INCRI x3 -> reg_n=3; i sequence 1, 2, 0; i_wrap high only the cycle after the third INCRI.
REQ-031 With n=2, INCRJ x2 -> j sequence 1, 0; j_wrap pulse; done=1 and stays 1 through a following INCRI; next SETN imm=5 -> done=0, i=j=0, n=5.
REQ-032 With n=4 and i=2, INCRI held 3 cycles with stall=1 -> i stays 2; after stall drops, INCRI once -> i=3.
REQ-033 With n=0, INCRI from i=0xFFFFFFFF -> i=0 and no i_wrap; INCRJ x2 -> j=2 and done stays 0.
REQ-034 With n=8 and i=5, SETN imm=4 then INCRI -> i=1 (SETN cleared i); separately force i=6 via n=8, then SETN is not issued and rst_n pulses low mid-cycle -> all outputs 0 immediately, before the next edge.
REQ-035 With SCA_REG_PERF_EN defined: 10 accepted ops (mix incl. op 11) plus 3 stalled cycles -> op_count=10; without the macro -> op_count=0.

Source files
------------

// File: rtl/sca_reg_unit.sv
// Scalar loop-register unit: i/j loop indices with wrap against bound n, sticky done flag.
// Optional accepted-op counter on op_count when SCA_REG_PERF_EN is defined; otherwise op_count is tied to 0.
module sca_reg_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        stall,
    input  logic [1:0]  sca_reg_op,
    input  logic [31:0] imm,
    output logic [31:0] reg_i,
    output logic [31:0] reg_j,
    output logic [31:0] reg_n,
    output logic        i_wrap,
    output logic        j_wrap,
    output logic        done,
    output logic [31:0] op_count
);

    localparam logic [1:0] OP_INCRI = 2'b00;
    localparam logic [1:0] OP_INCRJ = 2'b01;
    localparam logic [1:0] OP_SETN  = 2'b10;

    logic [31:0] reg_i_q, reg_i_d;
    logic [31:0] reg_j_q, reg_j_d;
    logic [31:0] reg_n_q, reg_n_d;
    logic        i_wrap_q, i_wrap_d;
    logic        j_wrap_q, j_wrap_d;
    logic        done_q, done_d;

    logic        accept;
    logic        n_zero;
    logic [32:0] i_inc;
    logic [32:0] j_inc;
    logic        i_hit;
    logic        j_hit;

    always_comb begin
        accept = valid_in & ~stall;
        n_zero = (reg_n_q == 32'd0);
        // 33-bit increment so an index of all-ones cannot alias to zero;
        // ">=" also folds in the index-already-past-bound case.
        i_inc  = {1'b0, reg_i_q} + 33'd1;
        j_inc  = {1'b0, reg_j_q} + 33'd1;
        i_hit  = !n_zero && (i_inc >= {1'b0, reg_n_q});
        j_hit  = !n_zero && (j_inc >= {1'b0, reg_n_q});

        reg_i_d  = reg_i_q;
        reg_j_d  = reg_j_q;
        reg_n_d  = reg_n_q;
        done_d   = done_q;
        i_wrap_d = 1'b0;
        j_wrap_d = 1'b0;

        if (accept) begin
            case (sca_reg_op)
                OP_INCRI: begin
                    if (i_hit) begin
                        reg_i_d  = 32'd0;
                        i_wrap_d = 1'b1;
                    end else begin
                        reg_i_d = i_inc[31:0];
                    end
                end
                OP_INCRJ: begin
                    if (j_hit) begin
                        reg_j_d  = 32'd0;
                        j_wrap_d = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        reg_j_d = j_inc[31:0];
                    end
                end
                OP_SETN: begin
                    reg_n_d = imm;
                    reg_i_d = 32'd0;
                    reg_j_d = 32'd0;
                    done_d  = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_i_q  <= 32'd0;
            reg_j_q  <= 32'd0;
            reg_n_q  <= 32'd0;
            i_wrap_q <= 1'b0;
            j_wrap_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            reg_i_q  <= reg_i_d;
            reg_j_q  <= reg_j_d;
            reg_n_q  <= reg_n_d;
            i_wrap_q <= i_wrap_d;
            j_wrap_q <= j_wrap_d;
            done_q   <= done_d;
        end
    end

    assign reg_i  = reg_i_q;
    assign reg_j  = reg_j_q;
    assign reg_n  = reg_n_q;
    assign i_wrap = i_wrap_q;
    assign j_wrap = j_wrap_q;
    assign done   = done_q;

`ifdef SCA_REG_PERF_EN
    logic [31:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = accept ? (op_count_q + 32'd1) : op_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 32'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_sca_reg_unit.sv
// Bench for sca_reg_unit: behavioural model checked every negedge, directed literal scenarios, random traffic.
module tb_sca_reg_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        stall;
    logic [1:0]  sca_reg_op;
    logic [31:0] imm;
    logic [31:0] reg_i, reg_j, reg_n, op_count;
    logic        i_wrap, j_wrap, done;

    int n_chk;
    int n_fail;

    sca_reg_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall),
        .sca_reg_op(sca_reg_op), .imm(imm),
        .reg_i(reg_i), .reg_j(reg_j), .reg_n(reg_n),
        .i_wrap(i_wrap), .j_wrap(j_wrap), .done(done), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    longint      m_i, m_j, m_n, m_cnt;
    bit          m_iw, m_jw, m_done;
    int          inj_req, inj_ack;
    int          inj_sel;
    longint      inj_val;
    longint      ci, cj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_i <= 0; m_j <= 0; m_n <= 0; m_cnt <= 0;
            m_iw <= 0; m_jw <= 0; m_done <= 0;
            inj_ack <= inj_req;
        end else begin
            ci = m_i;
            cj = m_j;
            if (inj_req != inj_ack) begin
                if (inj_sel == 0) ci = inj_val; else cj = inj_val;
            end
            inj_ack <= inj_req;
            m_i  <= ci;
            m_j  <= cj;
            m_iw <= 0;
            m_jw <= 0;
            if (valid_in && !stall) begin
                m_cnt <= (m_cnt + 1) % 64'h1_0000_0000;
                case (sca_reg_op)
                    2'd0: begin
                        if (m_n == 0) m_i <= (ci + 1) % 64'h1_0000_0000;
                        else if (ci + 1 == m_n || ci >= m_n) begin m_i <= 0; m_iw <= 1; end
                        else m_i <= ci + 1;
                    end
                    2'd1: begin
                        if (m_n == 0) m_j <= (cj + 1) % 64'h1_0000_0000;
                        else if (cj + 1 == m_n || cj >= m_n) begin m_j <= 0; m_jw <= 1; m_done <= 1; end
                        else m_j <= cj + 1;
                    end
                    2'd2: begin
                        m_n <= longint'(imm); m_i <= 0; m_j <= 0; m_done <= 0;
                    end
                    default: begin end
                endcase
            end
        end
    end

    function automatic longint exp_cnt();
`ifdef SCA_REG_PERF_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        n_chk++;
        if (longint'(reg_i) != m_i || longint'(reg_j) != m_j || longint'(reg_n) != m_n ||
            i_wrap != m_iw || j_wrap != m_jw || done != m_done || longint'(op_count) != exp_cnt()) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got i=%h j=%h n=%h iw=%b jw=%b d=%b cnt=%h need i=%h j=%h n=%h iw=%b jw=%b d=%b cnt=%h",
                     $time, reg_i, reg_j, reg_n, i_wrap, j_wrap, done, op_count,
                     m_i[31:0], m_j[31:0], m_n[31:0], m_iw, m_jw, m_done, exp_cnt());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h need=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] v);
        @(negedge clk);
        valid_in = 1'b1; stall = 1'b0; sca_reg_op = o; imm = v;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic inject(input int sel, input logic [31:0] v);
        @(negedge clk);
        #1;
        inj_sel = sel;
        inj_val = longint'(v);
        if (sel == 0) force dut.reg_i_q = v; else force dut.reg_j_q = v;
        inj_req = inj_req + 1;
        #1;
        if (sel == 0) release dut.reg_i_q; else release dut.reg_j_q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_i", reg_i, 0); chk("rst_j", reg_j, 0); chk("rst_n_reg", reg_n, 0);
        chk("rst_iw", {31'd0, i_wrap}, 0); chk("rst_jw", {31'd0, j_wrap}, 0);
        chk("rst_done", {31'd0, done}, 0); chk("rst_cnt", op_count, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        inj_req = 0; inj_sel = 0; inj_val = 0;
        rst_n = 1'b0; valid_in = 1'b0; stall = 1'b0; sca_reg_op = 2'b11; imm = 32'd0;
        #23;
        do_reset();

        // SETN 3 then INCRI x3
        do_op(2'b10, 32'd3); chk("n3", reg_n, 3);
        do_op(2'b00, 0); chk("i_seq1", reg_i, 1); chk("iw_seq1", {31'd0, i_wrap}, 0);
        do_op(2'b00, 0); chk("i_seq2", reg_i, 2); chk("iw_seq2", {31'd0, i_wrap}, 0);
        do_op(2'b00, 0); chk("i_seq3", reg_i, 0); chk("iw_seq3", {31'd0, i_wrap}, 1);
        @(posedge clk); #1 chk("iw_after", {31'd0, i_wrap}, 0);

        // n=2, j wrap and sticky done
        do_op(2'b10, 32'd2);
        do_op(2'b01, 0); chk("j_seq1", reg_j, 1); chk("done_pre", {31'd0, done}, 0);
        do_op(2'b01, 0); chk("j_seq2", reg_j, 0); chk("jw_pulse", {31'd0, j_wrap}, 1);
        chk("done_set", {31'd0, done}, 1);
        do_op(2'b00, 0); chk("done_sticky", {31'd0, done}, 1); chk("jw_low", {31'd0, j_wrap}, 0);
        do_op(2'b10, 32'd5); chk("done_clr", {31'd0, done}, 0);
        chk("setn_i", reg_i, 0); chk("setn_j", reg_j, 0); chk("setn_n", reg_n, 5);

        // stall holds the op
        do_op(2'b10, 32'd4); do_op(2'b00, 0); do_op(2'b00, 0);
        @(negedge clk);
        valid_in = 1'b1; stall = 1'b1; sca_reg_op = 2'b00;
        repeat (3) @(posedge clk);
        #1 chk("stall_hold", reg_i, 2);
        valid_in = 1'b0; stall = 1'b0;
        do_op(2'b00, 0); chk("after_stall", reg_i, 3);

        // n=0: free-running 32-bit increment, no wrap, done untouched
        do_op(2'b10, 32'd0);
        inject(0, 32'hFFFF_FFFF);
        do_op(2'b00, 0); chk("n0_i_roll", reg_i, 0); chk("n0_iw", {31'd0, i_wrap}, 0);
        do_op(2'b01, 0); do_op(2'b01, 0);
        chk("n0_j", reg_j, 2); chk("n0_done", {31'd0, done}, 0);

        // index already past bound wraps immediately
        do_op(2'b10, 32'd3);
        inject(1, 32'd7);
        do_op(2'b01, 0); chk("past_j", reg_j, 0); chk("past_jw", {31'd0, j_wrap}, 1);
        chk("past_done", {31'd0, done}, 1);

        // SETN shrinking n clears i
        do_op(2'b10, 32'd8);
        repeat (5) do_op(2'b00, 0);
        chk("i5", reg_i, 5);
        do_op(2'b10, 32'd4); do_op(2'b00, 0); chk("shrink_i", reg_i, 1);

        // mid-cycle reset with an op presented
        do_op(2'b10, 32'd8);
        repeat (6) do_op(2'b00, 0);
        chk("i6", reg_i, 6);
        @(negedge clk);
        valid_in = 1'b1; sca_reg_op = 2'b00;
        do_reset();
        valid_in = 1'b0;
        @(posedge clk); #1 chk("post_rst_i", reg_i, 0);

        // op counting: 10 accepted (incl. op 11) plus 3 stalled cycles
        do_reset();
        for (int k = 0; k < 10; k++) do_op(2'(k % 4), 32'd6);
        @(negedge clk);
        valid_in = 1'b1; stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 valid_in = 1'b0; stall = 1'b0;
`ifdef SCA_REG_PERF_EN
        chk("op_count10", op_count, 10);
`else
        chk("op_count0", op_count, 0);
`endif

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            int r;
            @(negedge clk);
            valid_in = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            r = int'($urandom_range(0, 15));
            sca_reg_op = (r < 6) ? 2'b00 : (r < 12) ? 2'b01 : (r < 13) ? 2'b10 : 2'b11;
            imm = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
        end
        @(negedge clk);
        valid_in = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
